// File: rtl/lab_005_alarm_ctrl.sv
// Five-state arming controller: exit delay, entry delay and timed siren around the sensor check.
// Optional door chime output is built when ALARM_CHIME_EN is defined.
module lab_005_alarm_ctrl #(
    parameter int EXIT_CYCLES  = 16,
    parameter int ENTRY_CYCLES = 8,
    parameter int SIREN_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm_req_i,
    input  logic       disarm_req_i,
    input  logic       alarm_stay_i,
    input  logic [1:0] doors_i,
    input  logic [2:0] windows_i,
    output logic       secure_o,
    output logic [2:0] state_o,
    output logic       armed_o,
    output logic       siren_o,
    output logic [7:0] countdown_o,
    output logic       arm_fault_o
`ifdef ALARM_CHIME_EN
    ,
    output logic       chime_o
`endif
);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_EXIT     = 3'd1,
        S_ARMED    = 3'd2,
        S_ENTRY    = 3'd3,
        S_ALARM    = 3'd4
    } state_e;

    localparam logic [7:0] EXIT_C  = 8'(EXIT_CYCLES);
    localparam logic [7:0] ENTRY_C = 8'(ENTRY_CYCLES);
    localparam logic [7:0] SIREN_C = 8'(SIREN_CYCLES);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       stay_q, stay_d;
    logic       fault_q, fault_d;
    logic       armed_q, armed_d;
    logic       siren_q, siren_d;
    logic       breach;
    logic       last_tick;

    assign secure_o  = ~|{doors_i, windows_i};
    // back door or any window is an immediate alarm once armed
    assign breach    = doors_i[1] | (|windows_i);
    assign last_tick = (cnt_q <= 8'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stay_d  = stay_q;
        fault_d = 1'b0;
        if (disarm_req_i) begin
            state_d = S_DISARMED;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                S_DISARMED: begin
                    cnt_d = 8'd0;
                    if (arm_req_i) begin
                        if (secure_o) begin
                            state_d = S_EXIT;
                            cnt_d   = EXIT_C;
                            stay_d  = alarm_stay_i;
                        end else begin
                            fault_d = 1'b1;
                        end
                    end
                end
                S_EXIT: begin
                    if (last_tick) begin
                        state_d = S_ARMED;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_ARMED: begin
                    cnt_d = 8'd0;
                    if (breach || (doors_i[0] && stay_q)) begin
                        state_d = S_ALARM;
                        cnt_d   = SIREN_C;
                    end else if (doors_i[0]) begin
                        state_d = S_ENTRY;
                        cnt_d   = ENTRY_C;
                    end
                end
                S_ENTRY: begin
                    if (breach || last_tick) begin
                        state_d = S_ALARM;
                        cnt_d   = SIREN_C;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_ALARM: begin
                    if (last_tick) begin
                        state_d = S_ARMED;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = S_DISARMED;
                    cnt_d   = 8'd0;
                end
            endcase
        end
        armed_d = (state_d == S_ARMED) || (state_d == S_ENTRY) || (state_d == S_ALARM);
        siren_d = (state_d == S_ALARM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DISARMED;
            cnt_q   <= 8'd0;
            stay_q  <= 1'b0;
            fault_q <= 1'b0;
            armed_q <= 1'b0;
            siren_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stay_q  <= stay_d;
            fault_q <= fault_d;
            armed_q <= armed_d;
            siren_q <= siren_d;
        end
    end

    assign state_o     = state_q;
    assign countdown_o = cnt_q;
    assign armed_o     = armed_q;
    assign siren_o     = siren_q;
    assign arm_fault_o = fault_q;

`ifdef ALARM_CHIME_EN
    logic door0_q;
    logic chime_q, chime_d;

    // rising edge of the entry door while the system is off
    assign chime_d = (state_q == S_DISARMED) && doors_i[0] && !door0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            door0_q <= 1'b0;
            chime_q <= 1'b0;
        end else begin
            door0_q <= doors_i[0];
            chime_q <= chime_d;
        end
    end

    assign chime_o = chime_q;
`endif

endmodule

// File: tb/tb_lab_005_alarm_ctrl.sv
// Bench for lab_005_alarm_ctrl: directed vector table, reset corner cases, then random traffic vs. a deadline model.
module tb_lab_005_alarm_ctrl;

    localparam int EXIT_N  = 4;
    localparam int ENTRY_N = 3;
    localparam int SIREN_N = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm_req = 1'b0, disarm_req = 1'b0, alarm_stay = 1'b0;
    logic [1:0] doors = 2'b00;
    logic [2:0] windows = 3'b000;
    logic       secure, armed, siren, arm_fault;
    logic [2:0] state;
    logic [7:0] countdown;
`ifdef ALARM_CHIME_EN
    logic       chime;
`endif

    int errors = 0;
    int checks = 0;

    lab_005_alarm_ctrl #(.EXIT_CYCLES(EXIT_N), .ENTRY_CYCLES(ENTRY_N), .SIREN_CYCLES(SIREN_N)) dut (
        .clk(clk), .rst_n(rst_n),
        .arm_req_i(arm_req), .disarm_req_i(disarm_req), .alarm_stay_i(alarm_stay),
        .doors_i(doors), .windows_i(windows),
        .secure_o(secure), .state_o(state), .armed_o(armed), .siren_o(siren),
        .countdown_o(countdown), .arm_fault_o(arm_fault)
`ifdef ALARM_CHIME_EN
        , .chime_o(chime)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       arm, dis, stay;
        logic [1:0] doors;
        logic [2:0] win;
        int         e_st, e_cnt, e_fault;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic row(input logic a, input logic d, input logic s, input logic [1:0] dr,
                       input logic [2:0] w, input int st, input int cnt, input int f);
        vec_t v;
        v.arm = a; v.dis = d; v.stay = s; v.doors = dr; v.win = w;
        v.e_st = st; v.e_cnt = cnt; v.e_fault = f;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic a, input logic d, input logic s, input logic [1:0] dr, input logic [2:0] w);
        @(negedge clk);
        arm_req = a; disarm_req = d; alarm_stay = s; doors = dr; windows = w;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int st, input int cnt, input int f);
        check({tag, ".state"}, int'(state), st);
        check({tag, ".countdown"}, int'(countdown), cnt);
        check({tag, ".armed"}, int'(armed), (st == 2 || st == 3 || st == 4) ? 1 : 0);
        check({tag, ".siren"}, int'(siren), (st == 4) ? 1 : 0);
        check({tag, ".arm_fault"}, int'(arm_fault), f);
        check({tag, ".secure"}, int'(secure), (doors == 2'b00 && windows == 3'b000) ? 1 : 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        arm_req = 1'b0; disarm_req = 1'b0; alarm_stay = 1'b0; doors = 2'b00; windows = 3'b000;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference: timed states remember the cycle number at which they expire.
    int m_mode, m_end, m_now, m_fault;
    logic m_stay;

    task automatic model_step(input logic a, input logic d, input logic s, input logic [1:0] dr, input logic [2:0] w);
        logic brk;
        brk = dr[1] || (w != 3'b000);
        m_now++;
        m_fault = 0;
        if (d) m_mode = 0;
        else case (m_mode)
            0: if (a) begin
                   if (dr == 2'b00 && w == 3'b000) begin m_mode = 1; m_end = m_now + EXIT_N; m_stay = s; end
                   else m_fault = 1;
               end
            1: if (m_now == m_end) m_mode = 2;
            2: if (brk || (dr[0] && m_stay)) begin m_mode = 4; m_end = m_now + SIREN_N; end
               else if (dr[0]) begin m_mode = 3; m_end = m_now + ENTRY_N; end
            3: if (brk || m_now == m_end) begin m_mode = 4; m_end = m_now + SIREN_N; end
            4: if (m_now == m_end) m_mode = 2;
            default: m_mode = 0;
        endcase
    endtask

    initial begin
        // away arm, entry delay, siren, auto-rearm
        row(1,0,0,2'b00,3'b000, 1,4,0);
        row(0,0,0,2'b00,3'b000, 1,3,0);
        row(0,0,0,2'b11,3'b111, 1,2,0);
        row(0,0,0,2'b00,3'b000, 1,1,0);
        row(0,0,0,2'b00,3'b000, 2,0,0);
        row(0,0,0,2'b01,3'b000, 3,3,0);
        row(0,0,0,2'b01,3'b000, 3,2,0);
        row(0,0,0,2'b00,3'b000, 3,1,0);
        row(0,0,0,2'b00,3'b000, 4,5,0);
        row(0,0,0,2'b00,3'b000, 4,4,0);
        row(0,0,0,2'b00,3'b000, 4,3,0);
        row(0,0,0,2'b00,3'b000, 4,2,0);
        row(0,0,0,2'b00,3'b000, 4,1,0);
        row(0,0,0,2'b00,3'b000, 2,0,0);
        row(0,1,0,2'b00,3'b000, 0,0,0);
        // rejected arm, arm+disarm together
        row(1,0,0,2'b00,3'b101, 0,0,1);
        row(0,0,0,2'b00,3'b101, 0,0,0);
        row(1,1,0,2'b00,3'b000, 0,0,0);
        // stay mode: entry door goes straight to alarm; arm_req during exit ignored
        row(1,0,1,2'b00,3'b000, 1,4,0);
        row(1,0,1,2'b00,3'b000, 1,3,0);
        row(0,0,0,2'b00,3'b000, 1,2,0);
        row(0,0,0,2'b00,3'b000, 1,1,0);
        row(0,0,0,2'b00,3'b000, 2,0,0);
        row(0,0,0,2'b01,3'b000, 4,5,0);
        row(0,1,0,2'b01,3'b000, 0,0,0);
        // away: window during entry delay
        row(1,0,0,2'b00,3'b000, 1,4,0);
        row(0,0,0,2'b00,3'b000, 1,3,0);
        row(0,0,0,2'b00,3'b000, 1,2,0);
        row(0,0,0,2'b00,3'b000, 1,1,0);
        row(0,0,0,2'b00,3'b000, 2,0,0);
        row(0,0,0,2'b01,3'b000, 3,3,0);
        row(0,0,0,2'b00,3'b100, 4,5,0);
        row(0,1,0,2'b00,3'b000, 0,0,0);
        // door held open through siren re-triggers entry delay
        row(1,0,0,2'b00,3'b000, 1,4,0);
        row(0,0,0,2'b00,3'b000, 1,3,0);
        row(0,0,0,2'b00,3'b000, 1,2,0);
        row(0,0,0,2'b00,3'b000, 1,1,0);
        row(0,0,0,2'b00,3'b000, 2,0,0);
        row(0,0,0,2'b01,3'b000, 3,3,0);
        row(0,0,0,2'b01,3'b000, 3,2,0);
        row(0,0,0,2'b01,3'b000, 3,1,0);
        row(0,0,0,2'b01,3'b000, 4,5,0);
        row(0,0,0,2'b01,3'b000, 4,4,0);
        row(0,0,0,2'b01,3'b000, 4,3,0);
        row(0,0,0,2'b01,3'b000, 4,2,0);
        row(0,0,0,2'b01,3'b000, 4,1,0);
        row(0,0,0,2'b01,3'b000, 2,0,0);
        row(0,0,0,2'b01,3'b000, 3,3,0);
        row(0,1,0,2'b00,3'b000, 0,0,0);

        // reset state
        #12;
        check_outs("reset", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            begin
                apply(vecs[i].arm, vecs[i].dis, vecs[i].stay, vecs[i].doors, vecs[i].win);
                check_outs($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_cnt, vecs[i].e_fault);
            end

        // async reset in the middle of exit delay
        apply(1,0,1,2'b00,3'b000);
        apply(0,0,0,2'b00,3'b000);
        check_outs("pre_rst", 1, 3, 0);
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0,0,0,2'b00,3'b000);
        check_outs("post_rst", 0, 0, 0);
        apply(0,0,0,2'b01,3'b000);
        check_outs("post_rst_door", 0, 0, 0);

`ifdef ALARM_CHIME_EN
        apply(0,0,0,2'b00,3'b000);
        check("chime.idle", int'(chime), 0);
        apply(0,0,0,2'b01,3'b000);
        check("chime.edge", int'(chime), 1);
        apply(0,0,0,2'b01,3'b000);
        check("chime.held", int'(chime), 0);
        apply(0,0,0,2'b01,3'b000);
        check("chime.held2", int'(chime), 0);
`endif

        // random traffic against the deadline model
        do_reset();
        m_mode = 0; m_end = 0; m_now = 0; m_fault = 0; m_stay = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic a, d, s;
            logic [1:0] dr;
            logic [2:0] w;
            a = ($urandom_range(5) == 0);
            d = ($urandom_range(19) == 0);
            s = 1'($urandom_range(1));
            dr = {($urandom_range(7) == 0), ($urandom_range(5) == 0)};
            w = {($urandom_range(11) == 0), ($urandom_range(11) == 0), ($urandom_range(11) == 0)};
            if (m_mode == 0 && $urandom_range(1) == 0) begin dr = 2'b00; w = 3'b000; end
            model_step(a, d, s, dr, w);
            apply(a, d, s, dr, w);
            check_outs($sformatf("rnd%0d", n), m_mode,
                       (m_mode == 1 || m_mode == 3 || m_mode == 4) ? (m_end - m_now) : 0, m_fault);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lab_005_alarm_ctrl.md
# lab_005_alarm_ctrl

Sequential arming controller for the lab 5 home alarm sensor set: two doors, three windows, away/stay modes. Adds exit delay, entry delay and a timed siren around the combinational sensor check, turning one-cycle arm/disarm requests into a five-state arming FSM. Sits between the keypad request logic and the siren/status LEDs; sensor inputs are already synchronised upstream.

## Interface
- EXIT_CYCLES, 16: cycles spent in EXIT_DELAY after arming (1..255)
- ENTRY_CYCLES, 8: cycles spent in ENTRY_DELAY after entry door opens (1..255)
- SIREN_CYCLES, 32: cycles siren sounds before auto-rearm (1..255)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- arm_req  in  1  one-cycle arm request
- disarm_req  in  1  one-cycle disarm request (valid code entered)
- alarm_stay  in  1  mode select sampled at arming: 1 = stay, 0 = away
- doors  in  2  door open flags; doors[0] = entry door, doors[1] = back door
- windows  in  3  window open flags
- secure  out  1  combinational, 1 when doors and windows all 0
- state  out  3  registered FSM state encoding
- armed  out  1  registered, 1 in ARMED, ENTRY_DELAY, ALARM
- siren  out  1  registered, 1 only in ALARM
- countdown  out  8  registered remaining cycles of current timed state, 0 otherwise
- arm_fault  out  1  registered one-cycle pulse: arm_req rejected because not secure

## Operation
- States: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4; 5-7 unused, recover to DISARMED next edge.
- DISARMED: arm_req & secure -> EXIT_DELAY, stay_q <= alarm_stay, countdown <= EXIT_CYCLES. arm_req & !secure -> stay, arm_fault=1 next cycle.
- EXIT_DELAY: sensors ignored; countdown decrements each cycle; on countdown==1 -> ARMED.
- ARMED: any window or doors[1] open -> ALARM. doors[0] open -> ENTRY_DELAY (countdown <= ENTRY_CYCLES) if stay_q=0, ALARM if stay_q=1.
- ENTRY_DELAY: countdown decrements; window or doors[1] open -> ALARM immediately; countdown==1 -> ALARM.
- ALARM: siren=1, countdown <= SIREN_CYCLES on entry, decrements; countdown==1 -> ARMED (re-triggers per ARMED rules if still open).
- disarm_req in any state -> DISARMED next edge, countdown=0; disarm_req has priority over arm_req and all sensor events in the same cycle.
- arm_req outside DISARMED ignored; alarm_stay only sampled on the arming edge.

## Timing
- Reset (async assert, sync release): state=DISARMED, armed=0, siren=0, countdown=0, arm_fault=0, stay_q=0.
- All transitions one clock after the causing input is sampled; outputs registered except secure.
- Each timed state lasts exactly its parameter count of cycles (countdown shows N..1).
- Reset asserted mid-delay or mid-siren: outputs to reset values immediately, no pending transitions.

## Configuration
- ALARM_CHIME_EN defined: extra output chime (1 bit, registered, reset 0) pulses one cycle when doors[0] goes 0->1 while DISARMED; requires a registered doors[0] history bit.
- Undefined: no chime port, no history register; all other behaviour identical.

## Test plan
Parameters EXIT_CYCLES=4, ENTRY_CYCLES=3, SIREN_CYCLES=5.
- Reset, then arm_req with all sensors 0, alarm_stay=0 -> state 1 for 4 cycles (countdown 4,3,2,1), then state 2, armed=1, siren=0.
- Armed away, doors=2'b01 -> state 3 for 3 cycles, then state 4, siren=1 for 5 cycles, back to state 2 (re-enters 3 if door still open).
- Armed stay, doors=2'b01 -> state 4 next cycle, siren=1; windows=3'b100 in away ENTRY_DELAY -> state 4 next cycle.
- arm_req with windows=3'b101 -> state stays 0, arm_fault=1 for one cycle; arm_req and disarm_req together -> state 0.
- disarm_req during ALARM -> state 0, siren=0, countdown=0 next cycle; rst_n low mid EXIT_DELAY -> all outputs 0 immediately.
- ALARM_CHIME_EN build: DISARMED, doors 00->01 -> chime=1 exactly one cycle; held 01 -> no further chime.
